// File: rtl/operand_bypass_pipe_if.sv
// Decode-to-execute bus for operand_bypass_pipe.
// Carries the pipeline controls, the operand sources, the ID/EX register outputs
// and the stall/bubble performance counters.
interface operand_bypass_pipe_if #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDRESS_BITS = 20
);
  logic                    stall;
  logic                    flush;
  logic [2:0]              rs1_data_bypass;
  logic [2:0]              rs2_data_bypass;
  logic [DATA_WIDTH-1:0]   rs1_data_regfile;
  logic [DATA_WIDTH-1:0]   rs2_data_regfile;
  logic [DATA_WIDTH-1:0]   execute_result;
  logic [DATA_WIDTH-1:0]   memory1_result;
  logic [DATA_WIDTH-1:0]   memory2_result;
  logic [DATA_WIDTH-1:0]   writeback_result;
  logic [31:0]             instruction_decode;
  logic [ADDRESS_BITS-1:0] pc_decode;
  logic [4:0]              rd_decode;
  logic                    regwrite_decode;

  logic [DATA_WIDTH-1:0]   rs1_data_execute;
  logic [DATA_WIDTH-1:0]   rs2_data_execute;
  logic [31:0]             instruction_execute;
  logic [ADDRESS_BITS-1:0] pc_execute;
  logic [4:0]              rd_execute;
  logic                    regwrite_execute;
  logic [6:0]              opcode_execute;
  logic                    valid_execute;
  logic                    hold_fetch;
  logic                    stall_error;
  logic [31:0]             stall_cycles;
  logic [31:0]             bubble_cycles;

  // Driver side: decode stage, forwarding network and hazard unit.
  modport master (
    output stall, flush, rs1_data_bypass, rs2_data_bypass,
           rs1_data_regfile, rs2_data_regfile,
           execute_result, memory1_result, memory2_result, writeback_result,
           instruction_decode, pc_decode, rd_decode, regwrite_decode,
    input  rs1_data_execute, rs2_data_execute, instruction_execute, pc_execute,
           rd_execute, regwrite_execute, opcode_execute, valid_execute,
           hold_fetch, stall_error, stall_cycles, bubble_cycles
  );

  // Pipeline register side.
  modport slave (
    input  stall, flush, rs1_data_bypass, rs2_data_bypass,
           rs1_data_regfile, rs2_data_regfile,
           execute_result, memory1_result, memory2_result, writeback_result,
           instruction_decode, pc_decode, rd_decode, regwrite_decode,
    output rs1_data_execute, rs2_data_execute, instruction_execute, pc_execute,
           rd_execute, regwrite_execute, opcode_execute, valid_execute,
           hold_fetch, stall_error, stall_cycles, bubble_cycles
  );
endinterface

// File: rtl/operand_bypass_pipe.sv
// ID/EX pipeline register with operand forwarding muxes, bubble insertion on
// stall/flush, a stall-run watchdog and optional performance counters.
// Optional feature: define STALL_PERF_COUNTER_EN to build the stall/bubble counters.
module operand_bypass_pipe #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDRESS_BITS = 20,
  parameter logic [31:0] NOP_INSTR    = 32'h00000013
) (
  input logic                  clock,
  input logic                  reset,
  operand_bypass_pipe_if.slave bus
);

  localparam logic [1:0] RUN_LIMIT = 2'd2;
  localparam logic [1:0] RUN_SAT   = 2'd3;

  logic [DATA_WIDTH-1:0]   rs1_q, rs1_d;
  logic [DATA_WIDTH-1:0]   rs2_q, rs2_d;
  logic [31:0]             instr_q, instr_d;
  logic [ADDRESS_BITS-1:0] pc_q, pc_d;
  logic [4:0]              rd_q, rd_d;
  logic                    regwrite_q, regwrite_d;
  logic                    valid_q, valid_d;
  logic [1:0]              run_q, run_d;
  logic                    error_q, error_d;
  logic                    stall_cycle;
  logic                    bubble;

  // Forwarding mux; unused select codes fall back to the register file.
  function automatic logic [DATA_WIDTH-1:0] select_operand(
    input logic [2:0]            sel,
    input logic [DATA_WIDTH-1:0] regfile,
    input logic [DATA_WIDTH-1:0] ex,
    input logic [DATA_WIDTH-1:0] mem1,
    input logic [DATA_WIDTH-1:0] mem2,
    input logic [DATA_WIDTH-1:0] wb
  );
    logic [DATA_WIDTH-1:0] result;
    case (sel)
      3'b001:  result = ex;
      3'b010:  result = mem1;
      3'b011:  result = mem2;
      3'b100:  result = wb;
      default: result = regfile;
    endcase
    return result;
  endfunction

  // Flush outranks stall, so a simultaneous redirect never counts as a stall.
  assign stall_cycle = bus.stall & ~bus.flush;
  assign bubble      = bus.stall | bus.flush;

  // Next ID/EX contents and stall-run watchdog update.
  always_comb begin
    rs1_d      = select_operand(bus.rs1_data_bypass, bus.rs1_data_regfile,
                                bus.execute_result, bus.memory1_result,
                                bus.memory2_result, bus.writeback_result);
    rs2_d      = select_operand(bus.rs2_data_bypass, bus.rs2_data_regfile,
                                bus.execute_result, bus.memory1_result,
                                bus.memory2_result, bus.writeback_result);
    instr_d    = bus.instruction_decode;
    pc_d       = bus.pc_decode;
    rd_d       = bus.rd_decode;
    regwrite_d = bus.regwrite_decode;
    valid_d    = 1'b1;
    run_d      = '0;
    error_d    = error_q;

    if (bubble) begin
      rs1_d      = '0;
      rs2_d      = '0;
      instr_d    = NOP_INSTR;
      rd_d       = '0;
      regwrite_d = 1'b0;
      valid_d    = 1'b0;
    end

    if (stall_cycle) begin
      run_d = (run_q == RUN_SAT) ? RUN_SAT : run_q + 2'd1;
      if (run_q >= RUN_LIMIT) begin
        error_d = 1'b1;
      end
    end
  end

  // ID/EX register; reset leaves a bubble in place.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rs1_q      <= '0;
      rs2_q      <= '0;
      instr_q    <= NOP_INSTR;
      pc_q       <= '0;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
      valid_q    <= 1'b0;
      run_q      <= '0;
      error_q    <= 1'b0;
    end else begin
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      rd_q       <= rd_d;
      regwrite_q <= regwrite_d;
      valid_q    <= valid_d;
      run_q      <= run_d;
      error_q    <= error_d;
    end
  end

  assign bus.rs1_data_execute    = rs1_q;
  assign bus.rs2_data_execute    = rs2_q;
  assign bus.instruction_execute = instr_q;
  assign bus.pc_execute          = pc_q;
  assign bus.rd_execute          = rd_q;
  assign bus.regwrite_execute    = regwrite_q;
  assign bus.valid_execute       = valid_q;
  assign bus.opcode_execute      = instr_q[6:0];
  assign bus.stall_error         = error_q;
  assign bus.hold_fetch          = stall_cycle & ~reset;

`ifdef STALL_PERF_COUNTER_EN
  logic [31:0] stall_count_q;
  logic [31:0] bubble_count_q;

  // Free-running wrap-around performance counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_count_q  <= '0;
      bubble_count_q <= '0;
    end else begin
      if (stall_cycle) begin
        stall_count_q <= stall_count_q + 32'd1;
      end
      if (bubble) begin
        bubble_count_q <= bubble_count_q + 32'd1;
      end
    end
  end

  assign bus.stall_cycles  = stall_count_q;
  assign bus.bubble_cycles = bubble_count_q;
`else
  assign bus.stall_cycles  = '0;
  assign bus.bubble_cycles = '0;
`endif

endmodule

// File: tb/tb_operand_bypass_pipe.sv
// Testbench for operand_bypass_pipe: directed scenarios followed by random traffic,
// all checked against a cycle-level reference model of the ID/EX stage.
module tb_operand_bypass_pipe;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 20;
  localparam logic [31:0] NOP = 32'h00000013;

  logic clock = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  // Reference model state
  logic [31:0]   m_instr;
  logic [AW-1:0] m_pc;
  logic [4:0]    m_rd;
  logic          m_regwrite;
  logic [DW-1:0] m_rs1;
  logic [DW-1:0] m_rs2;
  logic          m_valid;
  int            m_run;
  logic          m_error;
  logic [31:0]   m_stall_cnt;
  logic [31:0]   m_bubble_cnt;

  always #5 clock = ~clock;

  operand_bypass_pipe_if #(.DATA_WIDTH(DW), .ADDRESS_BITS(AW)) bus ();

  operand_bypass_pipe dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pick(input logic [2:0] sel, input logic [DW-1:0] rf);
    logic [DW-1:0] src [5];
    src[0] = rf;
    src[1] = bus.execute_result;
    src[2] = bus.memory1_result;
    src[3] = bus.memory2_result;
    src[4] = bus.writeback_result;
    return (int'(sel) <= 4) ? src[int'(sel)] : rf;
  endfunction

  task automatic model_reset();
    m_instr      = NOP;
    m_pc         = '0;
    m_rd         = '0;
    m_regwrite   = 1'b0;
    m_rs1        = '0;
    m_rs2        = '0;
    m_valid      = 1'b0;
    m_run        = 0;
    m_error      = 1'b0;
    m_stall_cnt  = '0;
    m_bubble_cnt = '0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".instr"},    bus.instruction_execute, m_instr);
    chk({tag, ".opcode"},   bus.opcode_execute, m_instr[6:0]);
    chk({tag, ".pc"},       bus.pc_execute, m_pc);
    chk({tag, ".rd"},       bus.rd_execute, m_rd);
    chk({tag, ".regwrite"}, bus.regwrite_execute, m_regwrite);
    chk({tag, ".rs1"},      bus.rs1_data_execute, m_rs1);
    chk({tag, ".rs2"},      bus.rs2_data_execute, m_rs2);
    chk({tag, ".valid"},    bus.valid_execute, m_valid);
    chk({tag, ".error"},    bus.stall_error, m_error);
    chk({tag, ".stalls"},   bus.stall_cycles, m_stall_cnt);
    chk({tag, ".bubbles"},  bus.bubble_cycles, m_bubble_cnt);
  endtask

  task automatic randomize_data();
    bus.rs1_data_regfile   = $urandom;
    bus.rs2_data_regfile   = $urandom;
    bus.execute_result     = $urandom;
    bus.memory1_result     = $urandom;
    bus.memory2_result     = $urandom;
    bus.writeback_result   = $urandom;
    bus.instruction_decode = $urandom;
    bus.pc_decode          = AW'($urandom);
    bus.rd_decode          = 5'($urandom);
    bus.regwrite_decode    = 1'($urandom);
    bus.rs1_data_bypass    = 3'($urandom_range(0, 7));
    bus.rs2_data_bypass    = 3'($urandom_range(0, 7));
  endtask

  // One clock with inputs already applied at the falling edge; returns at the next falling edge.
  task automatic cycle(input string tag);
    logic is_stall;
    logic is_bubble;
    logic [DW-1:0] n_rs1;
    logic [DW-1:0] n_rs2;
    #1;
    is_stall  = bus.stall && !bus.flush;
    is_bubble = bus.stall || bus.flush;
    chk({tag, ".hold_fetch"}, bus.hold_fetch, is_stall);
    n_rs1 = pick(bus.rs1_data_bypass, bus.rs1_data_regfile);
    n_rs2 = pick(bus.rs2_data_bypass, bus.rs2_data_regfile);
    m_pc = bus.pc_decode;
    if (is_bubble) begin
      m_instr = NOP; m_rd = '0; m_regwrite = 1'b0;
      m_rs1 = '0; m_rs2 = '0; m_valid = 1'b0;
    end else begin
      m_instr = bus.instruction_decode; m_rd = bus.rd_decode;
      m_regwrite = bus.regwrite_decode;
      m_rs1 = n_rs1; m_rs2 = n_rs2; m_valid = 1'b1;
    end
    if (is_stall) begin
      m_run++;
      if (m_run >= 3) m_error = 1'b1;
    end else begin
      m_run = 0;
    end
`ifdef STALL_PERF_COUNTER_EN
    if (is_stall)  m_stall_cnt  = m_stall_cnt + 32'd1;
    if (is_bubble) m_bubble_cnt = m_bubble_cnt + 32'd1;
`endif
    @(posedge clock);
    #1;
    check_all(tag);
    @(negedge clock);
  endtask

  initial begin
    reset     = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    randomize_data();
    model_reset();
    #2;
    check_all("reset_state");
    chk("reset_hold", bus.hold_fetch, 1'b0);
    @(negedge clock);
    reset = 1'b0;

    // Memory-1 forwarding wins over the register file.
    randomize_data();
    bus.rs1_data_bypass  = 3'b010;
    bus.memory1_result   = 32'hDEAD0001;
    bus.rs1_data_regfile = 32'h1;
    cycle("fwd_mem1");
    chk("fwd_mem1.value", bus.rs1_data_execute, 32'hDEAD0001);

    // Reserved select code falls back to the register file.
    randomize_data();
    bus.rs2_data_bypass  = 3'b110;
    bus.rs2_data_regfile = 32'h0000BEEF;
    cycle("sel110");
    chk("sel110.value", bus.rs2_data_execute, 32'h0000BEEF);

    // Every select code in turn.
    for (int s = 0; s < 8; s++) begin
      randomize_data();
      bus.rs1_data_bypass = 3'(s);
      bus.rs2_data_bypass = 3'(7 - s);
      cycle("sel_sweep");
    end

    // Single stall cycle inserts a bubble, then the held instruction issues.
    randomize_data();
    bus.instruction_decode = 32'h00A00093;
    bus.rd_decode          = 5'd1;
    bus.regwrite_decode    = 1'b1;
    bus.stall              = 1'b1;
    cycle("stall1");
    chk("stall1.nop", bus.instruction_execute, 32'h00000013);
    bus.stall = 1'b0;
    cycle("stall1_release");
    chk("stall1_release.instr", bus.instruction_execute, 32'h00A00093);
    chk("stall1_release.rd", bus.rd_execute, 5'd1);

    // Stall and flush together: flush wins.
    randomize_data();
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    cycle("stall_flush");
    bus.stall = 1'b0;
    bus.flush = 1'b0;

    // Two stalls do not trip the watchdog; the third does and it sticks.
    randomize_data();
    bus.stall = 1'b1;
    cycle("run1");
    cycle("run2");
    chk("run2.no_error", bus.stall_error, 1'b0);
    cycle("run3");
    chk("run3.error", bus.stall_error, 1'b1);
    cycle("run4");
    bus.stall = 1'b0;
    randomize_data();
    cycle("run_end");
    chk("run_end.sticky", bus.stall_error, 1'b1);

    // Asynchronous reset mid-stream with a valid instruction in execute.
    randomize_data();
    cycle("pre_reset");
    chk("pre_reset.valid", bus.valid_execute, 1'b1);
    bus.stall = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("async_reset");
    chk("async_reset.hold", bus.hold_fetch, 1'b0);
    @(posedge clock);
    #1;
    check_all("reset_held");
    @(negedge clock);
    reset     = 1'b0;
    bus.stall = 1'b0;
    randomize_data();
    cycle("first_after_reset");

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      randomize_data();
      bus.stall = ($urandom_range(0, 3) == 0);
      bus.flush = ($urandom_range(0, 7) == 0);
      cycle("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
